// File: rtl/cpu_control_unit_if.sv
// Bus between the multi-cycle sequencer and the datapath/memory it controls.
// master = the control unit, slave = the datapath side that drives run/op/mem_ready.
interface cpu_control_unit_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [3:0]       op;
    logic             mem_ready;
    logic             mem_req;
    logic             en_fetch;
    logic             en_decode;
    logic             en_regread;
    logic             en_alu;
    logic             en_mem;
    logic             en_regwrite;
    logic             pc_inc;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  run, op, mem_ready,
        output mem_req, en_fetch, en_decode, en_regread, en_alu, en_mem,
               en_regwrite, pc_inc, halted, state, retired_count
    );

    modport slave (
        output run, op, mem_ready,
        input  mem_req, en_fetch, en_decode, en_regread, en_alu, en_mem,
               en_regwrite, pc_inc, halted, state, retired_count
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle instruction sequencer (fetch/decode/regread/execute/memory/writeback/halt).
// Optional STEP_MODE_EN: a one-cycle `step` pulse in IDLE runs exactly one instruction.
module cpu_control_unit #(
    parameter logic [3:0] OP_LOAD  = 4'h8,
    parameter logic [3:0] OP_STORE = 4'h9,
    parameter logic [3:0] OP_HALT  = 4'hF,
    parameter int         CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
`ifdef STEP_MODE_EN
    input  logic              step,
`endif
    cpu_control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_REGREAD   = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEMORY    = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    state_t           state_r;
    state_t           next_s;
    state_t           after_retire_s;
    logic             retire_s;
    logic [CNT_W-1:0] count_r;

    logic mem_req_s, en_fetch_s, en_decode_s, en_regread_s, en_alu_s;
    logic en_mem_s, en_regwrite_s, pc_inc_s, halted_s;

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_s;
            if (retire_s) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Next-state logic; run is only looked at in IDLE and on retire
    always_comb begin
        next_s   = state_r;
        retire_s = 1'b0;
`ifdef STEP_MODE_EN
        after_retire_s = S_IDLE;
`else
        if (bus.run) begin
            after_retire_s = S_FETCH;
        end else begin
            after_retire_s = S_IDLE;
        end
`endif
        case (state_r)
            S_IDLE: begin
`ifdef STEP_MODE_EN
                if (step) begin
`else
                if (bus.run) begin
`endif
                    next_s = S_FETCH;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    next_s = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE:  next_s = S_REGREAD;
            S_REGREAD: begin
                if (bus.op == OP_HALT) begin
                    next_s = S_HALT;
                end else begin
                    next_s = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if ((bus.op == OP_LOAD) || (bus.op == OP_STORE)) begin
                    next_s = S_MEMORY;
                end else begin
                    next_s = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (!bus.mem_ready) begin
                    next_s = S_MEMORY;
                end else if (bus.op == OP_LOAD) begin
                    next_s = S_WRITEBACK;
                end else begin
                    // A store finishes here without a writeback
                    retire_s = 1'b1;
                    next_s   = after_retire_s;
                end
            end
            S_WRITEBACK: begin
                retire_s = 1'b1;
                next_s   = after_retire_s;
            end
            S_HALT:  next_s = S_HALT;
            default: next_s = S_IDLE;
        endcase
    end

    // Output decode from the registered state; pc_inc also qualifies on mem_ready
    always_comb begin
        mem_req_s     = 1'b0;
        en_fetch_s    = 1'b0;
        en_decode_s   = 1'b0;
        en_regread_s  = 1'b0;
        en_alu_s      = 1'b0;
        en_mem_s      = 1'b0;
        en_regwrite_s = 1'b0;
        pc_inc_s      = 1'b0;
        halted_s      = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                en_fetch_s = 1'b1;
                pc_inc_s   = bus.mem_ready;
            end
            S_DECODE:    en_decode_s   = 1'b1;
            S_REGREAD:   en_regread_s  = 1'b1;
            S_EXECUTE:   en_alu_s      = 1'b1;
            S_MEMORY: begin
                mem_req_s = 1'b1;
                en_mem_s  = 1'b1;
            end
            S_WRITEBACK: en_regwrite_s = 1'b1;
            S_HALT:      halted_s      = 1'b1;
            default:     halted_s      = 1'b0;
        endcase
    end

    assign bus.mem_req       = mem_req_s;
    assign bus.en_fetch      = en_fetch_s;
    assign bus.en_decode     = en_decode_s;
    assign bus.en_regread    = en_regread_s;
    assign bus.en_alu        = en_alu_s;
    assign bus.en_mem        = en_mem_s;
    assign bus.en_regwrite   = en_regwrite_s;
    assign bus.pc_inc        = pc_inc_s;
    assign bus.halted        = halted_s;
    assign bus.state         = state_r;
    assign bus.retired_count = count_r;

endmodule
